// File: rtl/johnson_pkg.sv
// Johnson code helpers shared by the counter, the phase decoder and their benches.
// Functions work on a MAX_W-bit zero-extended code plus the live width.
package johnson_pkg;

   localparam int MAX_W = 32;

   function automatic logic [MAX_W-1:0] low_ones(input int n);
      low_ones = '0;
      for (int i = 0; i < MAX_W; i++)
         if (i < n) low_ones[i] = 1'b1;
   endfunction

   function automatic bit is_legal_johnson(input logic [MAX_W-1:0] code, input int width);
      is_legal_johnson = 1'b0;
      for (int k = 0; k <= MAX_W; k++)
         if (k <= width && code == low_ones(k)) is_legal_johnson = 1'b1;
      for (int j = 1; j < MAX_W; j++)
         if (j < width && code == (low_ones(width) & ~low_ones(width - j)))
            is_legal_johnson = 1'b1;
   endfunction

   // LSB-anchored run of k ones is phase k; MSB-anchored run of j ones is phase 2W-j.
   function automatic int johnson_to_phase(input logic [MAX_W-1:0] code, input int width);
      johnson_to_phase = 0;
      for (int k = 0; k <= MAX_W; k++)
         if (k <= width && code == low_ones(k)) johnson_to_phase = k;
      for (int j = 1; j < MAX_W; j++)
         if (j < width && code == (low_ones(width) & ~low_ones(width - j)))
            johnson_to_phase = 2 * width - j;
   endfunction

   function automatic logic [MAX_W-1:0] johnson_next(input logic [MAX_W-1:0] code, input int width);
      logic [MAX_W-1:0] shifted;
      shifted = code << 1;
      shifted[0] = ~code[width-1];
      johnson_next = shifted & low_ones(width);
   endfunction

endpackage

// File: rtl/johnson_code_check.sv
// Combinational legality check and phase decode of one Johnson code sample.
module johnson_code_check
   import johnson_pkg::*;
#(
   parameter int WIDTH = 4,
   localparam int IDX_W = $clog2(2 * WIDTH)
) (
   input  logic [WIDTH-1:0] count_in,
   output logic             legal,
   output logic [IDX_W-1:0] phase
);

   logic [MAX_W-1:0] code_ext;

   assign code_ext = MAX_W'(count_in);
   assign legal    = is_legal_johnson(code_ext, WIDTH);
   assign phase    = IDX_W'(johnson_to_phase(code_ext, WIDTH));

endmodule

// File: rtl/johnson_phase_decoder.sv
// Registers the decoded Johnson phase, checks step-by-step progress,
// counts completed laps and keeps sticky illegal/sequence error flags.
module johnson_phase_decoder
   import johnson_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int LAP_W = 8,
   localparam int IDX_W = $clog2(2 * WIDTH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [WIDTH-1:0]   count_in,
   input  logic               err_clr,
   output logic [2*WIDTH-1:0] phase_onehot,
   output logic [IDX_W-1:0]   phase_idx,
   output logic               phase_valid,
   output logic               wrap,
   output logic [LAP_W-1:0]   lap_cnt,
   output logic               illegal_err,
   output logic               seq_err
);

   localparam int PH_W = 2 * WIDTH;
   localparam logic [IDX_W-1:0] LAST_PHASE = IDX_W'(PH_W - 1);

   logic             cur_legal;
   logic [IDX_W-1:0] cur_phase;
   logic             prev_valid;

   logic [PH_W-1:0]  phase_onehot_n;
   logic [IDX_W-1:0] phase_idx_n;
   logic [IDX_W-1:0] succ_phase;
   logic             in_step;
   logic             seq_evt;
   logic             wrap_evt;
   logic             illegal_err_n;
   logic             seq_err_n;
   logic [LAP_W-1:0] lap_cnt_n;

   johnson_code_check #(.WIDTH(WIDTH)) u_check (
      .count_in (count_in),
      .legal    (cur_legal),
      .phase    (cur_phase)
   );

   // phase_idx holds the last legal phase, so it doubles as the sequence reference.
   always_comb begin
      succ_phase     = (phase_idx == LAST_PHASE) ? '0 : phase_idx + 1'b1;
      in_step        = (cur_phase == phase_idx) || (cur_phase == succ_phase);
      seq_evt        = prev_valid && cur_legal && !in_step;
      wrap_evt       = prev_valid && cur_legal && (phase_idx == LAST_PHASE) && (cur_phase == '0);
      phase_onehot_n = '0;
      phase_idx_n    = phase_idx;
      if (cur_legal) begin
         phase_onehot_n = PH_W'(1) << cur_phase;
         phase_idx_n    = cur_phase;
      end
      illegal_err_n = !cur_legal || (illegal_err && !err_clr);
      seq_err_n     = seq_evt || (seq_err && !err_clr);
      lap_cnt_n     = lap_cnt + {{(LAP_W-1){1'b0}}, wrap_evt};
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         phase_onehot <= '0;
         phase_idx    <= '0;
         phase_valid  <= 1'b0;
         wrap         <= 1'b0;
         lap_cnt      <= '0;
         illegal_err  <= 1'b0;
         seq_err      <= 1'b0;
         prev_valid   <= 1'b0;
      end else begin
         phase_onehot <= phase_onehot_n;
         phase_idx    <= phase_idx_n;
         phase_valid  <= cur_legal;
         wrap         <= wrap_evt;
         lap_cnt      <= lap_cnt_n;
         illegal_err  <= illegal_err_n;
         seq_err      <= seq_err_n;
         prev_valid   <= cur_legal;
      end
   end

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Scoreboard bench for johnson_phase_decoder at WIDTH=4, LAP_W=8.
module tb_johnson_phase_decoder;

   typedef struct packed {
      logic [7:0] onehot;
      logic [2:0] idx;
      logic       valid;
      logic       wrap;
      logic [7:0] lap;
      logic       ill;
      logic       seq;
   } out_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] count_in = 4'b0000;
   logic       err_clr = 1'b0;
   logic [7:0] phase_onehot;
   logic [2:0] phase_idx;
   logic       phase_valid;
   logic       wrap;
   logic [7:0] lap_cnt;
   logic       illegal_err;
   logic       seq_err;

   johnson_phase_decoder #(.WIDTH(4), .LAP_W(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .count_in     (count_in),
      .err_clr      (err_clr),
      .phase_onehot (phase_onehot),
      .phase_idx    (phase_idx),
      .phase_valid  (phase_valid),
      .wrap         (wrap),
      .lap_cnt      (lap_cnt),
      .illegal_err  (illegal_err),
      .seq_err      (seq_err)
   );

   always #5 clk = ~clk;

   out_t sb[$];
   int   checks = 0;
   int   errors = 0;

   bit m_pv;
   int m_idx, m_lap;
   bit m_ill, m_seq;

   out_t exp_o, got_o;

   function automatic int tb_decode(input logic [3:0] c);
      case (c)
         4'b0000: return 0;
         4'b0001: return 1;
         4'b0011: return 2;
         4'b0111: return 3;
         4'b1111: return 4;
         4'b1110: return 5;
         4'b1100: return 6;
         4'b1000: return 7;
         default: return -1;
      endcase
   endfunction

   function automatic out_t sample();
      out_t o;
      o.onehot = phase_onehot;
      o.idx    = phase_idx;
      o.valid  = phase_valid;
      o.wrap   = wrap;
      o.lap    = lap_cnt;
      o.ill    = illegal_err;
      o.seq    = seq_err;
      return o;
   endfunction

   // Drive one sample, push the model's prediction, and advance past the capturing edge.
   task automatic drive(input logic [3:0] code, input logic clr, input logic rst_n);
      out_t e;
      int   p, d;
      bit   w;
      e = '0;
      w = 1'b0;
      if (!rst_n) begin
         m_pv = 0; m_idx = 0; m_lap = 0; m_ill = 0; m_seq = 0;
      end else begin
         p = tb_decode(code);
         if (p < 0) begin
            m_ill = 1;
            m_seq = m_seq & ~clr;
            m_pv  = 0;
         end else begin
            d     = (p - m_idx + 8) % 8;
            w     = m_pv && (m_idx == 7) && (p == 0);
            m_seq = (m_pv && d > 1) | (m_seq & ~clr);
            m_ill = m_ill & ~clr;
            m_idx = p;
            m_pv  = 1;
            if (w) m_lap = (m_lap + 1) % 256;
            e.valid  = 1'b1;
            e.onehot = 8'd1 << p;
         end
         e.idx  = 3'(m_idx);
         e.wrap = w;
         e.lap  = 8'(m_lap);
         e.ill  = m_ill;
         e.seq  = m_seq;
      end
      sb.push_back(e);
      @(negedge clk);
      count_in = code;
      err_clr  = clr;
      reset    = rst_n;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         drive(4'b0110, 1'b0, 1'b0);
         exp_o = sb.pop_front(); got_o = sample(); checks++;
         if (got_o !== exp_o) begin errors++; $display("FAIL reset_hold got=%h exp=%h", got_o, exp_o); end
      end
      drive(4'b0000, 1'b0, 1'b1);
      exp_o = sb.pop_front(); got_o = sample(); checks++;
      if (got_o !== exp_o) begin errors++; $display("FAIL reset_first got=%h exp=%h", got_o, exp_o); end
      checks++;
      if (phase_onehot !== 8'h01 || phase_idx !== 3'd0 || phase_valid !== 1'b1 || seq_err !== 1'b0 || wrap !== 1'b0) begin
         errors++;
         $display("FAIL reset_first_const got oh=%h idx=%0d v=%b seq=%b wrap=%b exp oh=01 idx=0 v=1 seq=0 wrap=0",
                  phase_onehot, phase_idx, phase_valid, seq_err, wrap);
      end
   endtask

   task automatic test_full_sequence();
      logic [3:0] seq_codes [9] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                    4'b1110, 4'b1100, 4'b1000, 4'b0000};
      int wraps = 0;
      for (int i = 0; i < 9; i++) begin
         drive(seq_codes[i], 1'b0, 1'b1);
         exp_o = sb.pop_front(); got_o = sample(); checks++;
         if (got_o !== exp_o) begin errors++; $display("FAIL full_seq[%0d] got=%h exp=%h", i, got_o, exp_o); end
         if (wrap === 1'b1) wraps++;
      end
      checks++;
      if (wraps !== 1 || lap_cnt !== 8'd1 || phase_idx !== 3'd0) begin
         errors++;
         $display("FAIL full_seq_lap got wraps=%0d lap=%0d idx=%0d exp wraps=1 lap=1 idx=0", wraps, lap_cnt, phase_idx);
      end
   endtask

   task automatic test_hold();
      for (int i = 0; i < 6; i++) begin
         drive((i < 2) ? ((i == 0) ? 4'b0001 : 4'b0011) : 4'b0111, 1'b0, 1'b1);
         exp_o = sb.pop_front(); got_o = sample(); checks++;
         if (got_o !== exp_o) begin errors++; $display("FAIL hold[%0d] got=%h exp=%h", i, got_o, exp_o); end
      end
      drive(4'b1111, 1'b0, 1'b1);
      exp_o = sb.pop_front(); got_o = sample(); checks++;
      if (got_o !== exp_o || phase_idx !== 3'd4 || seq_err !== 1'b0) begin
         errors++; $display("FAIL hold_release got=%h exp=%h (idx 4 seq 0)", got_o, exp_o);
      end
   endtask

   task automatic test_jump();
      logic [3:0] codes [5] = '{4'b0001, 4'b0001, 4'b1110, 4'b1100, 4'b1000};
      logic       clrs  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 5; i++) begin
         drive(codes[i], clrs[i], 1'b1);
         exp_o = sb.pop_front(); got_o = sample(); checks++;
         if (got_o !== exp_o) begin errors++; $display("FAIL jump[%0d] got=%h exp=%h", i, got_o, exp_o); end
         if (i == 2) begin
            checks++;
            if (seq_err !== 1'b1 || phase_idx !== 3'd5) begin
               errors++; $display("FAIL jump_flag got seq=%b idx=%0d exp seq=1 idx=5", seq_err, phase_idx);
            end
         end
      end
      checks++;
      if (seq_err !== 1'b0) begin errors++; $display("FAIL jump_clear got seq=%b exp 0", seq_err); end
   endtask

   task automatic test_illegal();
      drive(4'b0101, 1'b0, 1'b1);
      exp_o = sb.pop_front(); got_o = sample(); checks++;
      if (got_o !== exp_o || phase_valid !== 1'b0 || phase_onehot !== 8'h00 || illegal_err !== 1'b1) begin
         errors++; $display("FAIL illegal got=%h exp=%h", got_o, exp_o);
      end
      drive(4'b1100, 1'b0, 1'b1);
      exp_o = sb.pop_front(); got_o = sample(); checks++;
      if (got_o !== exp_o || phase_idx !== 3'd6 || seq_err !== 1'b0) begin
         errors++; $display("FAIL illegal_recover got=%h exp=%h (idx 6 seq 0)", got_o, exp_o);
      end
      drive(4'b0101, 1'b1, 1'b1);
      exp_o = sb.pop_front(); got_o = sample(); checks++;
      if (got_o !== exp_o || illegal_err !== 1'b1) begin
         errors++; $display("FAIL clr_vs_set got=%h exp=%h (ill 1)", got_o, exp_o);
      end
      drive(4'b0000, 1'b1, 1'b1);
      exp_o = sb.pop_front(); got_o = sample(); checks++;
      if (got_o !== exp_o || illegal_err !== 1'b0) begin
         errors++; $display("FAIL clr_only got=%h exp=%h (ill 0)", got_o, exp_o);
      end
   endtask

   task automatic test_lap_wrap();
      logic [3:0] lap_codes [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                   4'b1110, 4'b1100, 4'b1000, 4'b0000};
      int wraps = 0;
      drive(4'b0000, 1'b0, 1'b0);
      exp_o = sb.pop_front(); got_o = sample(); checks++;
      if (got_o !== exp_o) begin errors++; $display("FAIL lap_reset got=%h exp=%h", got_o, exp_o); end
      drive(4'b0000, 1'b0, 1'b1);
      exp_o = sb.pop_front(); got_o = sample(); checks++;
      if (got_o !== exp_o) begin errors++; $display("FAIL lap_start got=%h exp=%h", got_o, exp_o); end
      for (int l = 0; l < 256; l++) begin
         for (int i = 0; i < 8; i++) begin
            drive(lap_codes[i], 1'b0, 1'b1);
            exp_o = sb.pop_front(); got_o = sample(); checks++;
            if (got_o !== exp_o) begin errors++; $display("FAIL lap[%0d][%0d] got=%h exp=%h", l, i, got_o, exp_o); end
            if (wrap === 1'b1) wraps++;
         end
      end
      checks++;
      if (wraps !== 256 || lap_cnt !== 8'd0) begin
         errors++; $display("FAIL lap_rollover got wraps=%0d lap=%0d exp wraps=256 lap=0", wraps, lap_cnt);
      end
      drive(4'b0001, 1'b0, 1'b1);
      exp_o = sb.pop_front(); got_o = sample(); checks++;
      if (got_o !== exp_o) begin errors++; $display("FAIL midlap_a got=%h exp=%h", got_o, exp_o); end
      drive(4'b0111, 1'b0, 1'b0);
      exp_o = sb.pop_front(); got_o = sample(); checks++;
      if (got_o !== exp_o || lap_cnt !== 8'd0 || wrap !== 1'b0 || phase_valid !== 1'b0) begin
         errors++; $display("FAIL midlap_reset got=%h exp=%h", got_o, exp_o);
      end
   endtask

   task automatic test_first_after_reset();
      drive(4'b1000, 1'b0, 1'b1);
      exp_o = sb.pop_front(); got_o = sample(); checks++;
      if (got_o !== exp_o || seq_err !== 1'b0) begin
         errors++; $display("FAIL first_unchecked got=%h exp=%h", got_o, exp_o);
      end
      drive(4'b0000, 1'b0, 1'b0);
      exp_o = sb.pop_front(); got_o = sample(); checks++;
      if (got_o !== exp_o) begin errors++; $display("FAIL rst_again got=%h exp=%h", got_o, exp_o); end
      drive(4'b0000, 1'b0, 1'b1);
      exp_o = sb.pop_front(); got_o = sample(); checks++;
      if (got_o !== exp_o || wrap !== 1'b0 || lap_cnt !== 8'd0) begin
         errors++; $display("FAIL first_no_wrap got=%h exp=%h", got_o, exp_o);
      end
   endtask

   initial begin
      test_reset();
      test_full_sequence();
      test_hold();
      test_jump();
      test_illegal();
      test_lap_wrap();
      test_first_after_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/johnson_phase_decoder.md
Name: johnson_phase_decoder

Overview:
- Downstream stage of the Johnson counter: samples its WIDTH-bit count every cycle and decodes it into a registered one-hot phase vector plus a binary phase index.
- Validates the stream: flags codes outside the Johnson set and legal codes that skip a step.
- Counts completed laps for the phase-sequencing logic that consumes it.

Parameters:
- WIDTH, 4, Johnson counter width; phases = 2*WIDTH; minimum 2.
- IDX_W, $clog2(2*WIDTH), phase index width (derived, not overridden).
- LAP_W, 8, lap counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- count_in  in  WIDTH  Johnson count from the counter.
- err_clr  in  1  clears the sticky error flags.
- phase_onehot  out  2*WIDTH  registered one-hot phase; all zero when invalid.
- phase_idx  out  IDX_W  registered binary phase, 0..2*WIDTH-1.
- phase_valid  out  1  the last sample was a legal Johnson code.
- wrap  out  1  one-cycle pulse on the phase 2W-1 -> 0 transition.
- lap_cnt  out  LAP_W  completed laps, wraps modulo 2^LAP_W.
- illegal_err  out  1  sticky: an illegal code was seen.
- seq_err  out  1  sticky: a legal code that was neither a hold nor the successor.

Behaviour:
- Reset (reset==0 at a clk edge): every output = 0; internal prev_valid = 0.
- Sequence convention: next = {count[WIDTH-2:0], ~count[WIDTH-1]}. For WIDTH=4: 0000,0001,0011,0111,1111,1110,1100,1000, then back to 0000.
- Legal code: a contiguous run of ones anchored at the LSB (k ones, k=0..W, phase k), or a contiguous run of ones anchored at the MSB (j ones, j=1..W-1, phase 2W-j).
- Latency: one cycle. Outputs at edge n+1 reflect count_in at edge n.
- Legal sample:
  - phase_valid=1.
  - phase_idx = decoded phase.
  - phase_onehot[phase]=1, all other bits 0.
- Illegal sample (e.g. 0101):
  - phase_valid=0, phase_onehot=0, phase_idx holds its last value.
  - illegal_err set.
  - prev_valid cleared, so the next legal code is not sequence-checked.
- Sequence check runs only when prev_valid=1 and the current sample is legal:
  - new phase == previous phase (hold) -> OK.
  - new phase == (previous+1) mod 2W -> OK.
  - anything else -> seq_err set.
  - After a seq_err the new phase becomes the reference; no re-flagging of the next in-step code.
- wrap=1 for exactly one cycle when previous phase = 2W-1, the new phase = 0, and both are legal.
  - lap_cnt increments on that same edge.
  - lap_cnt wraps from all-ones to 0 with no saturation.
- Sticky errors:
  - A single cycle of err_clr=1 clears both sticky flags.
  - If err_clr and a new error event occur in the same cycle, set wins and the flag stays 1.
  - err_clr does not touch lap_cnt or the phase outputs.
- Reset mid-operation: synchronous. The next edge with reset==0 zeroes everything.
  - After release, the first sample is decoded but not sequence-checked.
  - wrap cannot fire on the first sample.
- The first sample after reset is code 0000: phase 0, wrap=0 (no prior phase).

Decomposition:
- Package johnson_pkg holds:
  - function is_legal_johnson(code) -> bit;
  - function johnson_to_phase(code) -> index;
  - function johnson_next(code).
- The counter and its bench reuse the same package.
- One natural sub-module: johnson_code_check. It is combinational legality + phase decode, instantiated once; the top holds the registers, sequence check, lap counter and sticky flags.

Test Plan:
- Reset low 3 cycles with count_in=0110 -> all outputs 0. Release, drive 0000 -> next cycle phase_idx=0, phase_onehot=00000001, phase_valid=1, seq_err=0.
- Drive the full legal sequence 0000,0001,0011,0111,1111,1110,1100,1000,0000 -> phase_idx 0..7,0. wrap=1 only on the cycle after 0000 follows 1000. lap_cnt 0 -> 1.
- Hold 0111 for 4 cycles, then 1111 -> phase_idx stays 3, then 4. seq_err stays 0.
- Jump 0001 -> 1110 -> seq_err=1, phase_idx=5. Continue 1100 -> no new flag. Pulse err_clr -> seq_err=0 next cycle.
- Inject 0101 -> phase_valid=0, phase_onehot=0, illegal_err=1. Then 1100 -> phase_idx=6, seq_err unchanged (not checked).
- Run 256 full laps with LAP_W=8 -> lap_cnt wraps to 0 with a wrap pulse on each lap. Assert reset mid-lap -> lap_cnt=0, wrap=0 next edge.
